// File: rtl/shift_pkg.sv
// Shared definitions for the shift window counter: legal DEPTH range,
// shift direction encoding and a popcount helper.
package shift_pkg;

   localparam int DEPTH_MIN = 2;
   localparam int DEPTH_MAX = 64;
   localparam int ONES_MAX_W = $clog2(DEPTH_MAX + 1);

   typedef enum logic {
      SHIFT_LEFT  = 1'b0,
      SHIFT_RIGHT = 1'b1
   } shift_dir_e;

   // Callers zero-extend narrower windows to DEPTH_MAX bits.
   function automatic logic [ONES_MAX_W-1:0] popcount(input logic [DEPTH_MAX-1:0] v);
      logic [ONES_MAX_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH_MAX; i++) begin
         n = n + ONES_MAX_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag and a clear that
// still honours a coincident increment.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         sat
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] count_nx;

   // NOTE: combinational blocks give every output a default first so no
   // path through them leaves a variable unassigned and infers a latch.
   always_comb begin
      count_nx = count;
      if (clr) begin
         count_nx = inc ? W'(1) : '0;
      end else if (inc && (count != MAX)) begin
         count_nx = count + W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every
   // register samples the pre-edge values no matter how blocks are ordered.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= count_nx;
         if (clr) begin
            sat <= 1'b0;
         end else if (count_nx == MAX) begin
            sat <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/shift_window_counter.sv
// Bidirectional serial shift window with incremental ones count, fill
// tracking, registered pattern match and a saturating total ones counter.
module shift_window_counter
   import shift_pkg::*;
#(
   parameter int               DEPTH   = 8,
   parameter int               COUNT_W = 32,
   parameter logic [DEPTH-1:0] PATTERN = 8'hA5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic                       in_bit,
   input  logic                       dir,
   input  logic                       load,
   input  logic [DEPTH-1:0]           load_data,
   input  logic                       clr_count,
   output logic                       bit_out,
   output logic                       out_valid,
   output logic [DEPTH-1:0]           window,
   output logic [$clog2(DEPTH+1)-1:0] window_ones,
   output logic [COUNT_W-1:0]         total_count,
   output logic                       total_sat,
   output logic                       full,
   output logic                       match
);

   localparam int                 ONES_W   = $clog2(DEPTH + 1);
   localparam logic [ONES_W-1:0]  FILL_MAX = ONES_W'(DEPTH);

   if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("shift_window_counter: DEPTH out of legal range");
   end

   logic [ONES_W-1:0] fill;
   logic [DEPTH-1:0]  window_nx;
   logic [ONES_W-1:0] ones_nx;
   logic [ONES_W-1:0] fill_nx;
   logic              bit_out_nx;
   logic              out_valid_nx;
   logic              outgoing;

   assign full = (fill == FILL_MAX);

   always_comb begin
      window_nx    = window;
      ones_nx      = window_ones;
      fill_nx      = fill;
      bit_out_nx   = bit_out;
      out_valid_nx = 1'b0;
      outgoing     = 1'b0;
      if (load) begin
         window_nx = load_data;
         ones_nx   = ONES_W'(popcount(DEPTH_MAX'(load_data)));
         fill_nx   = FILL_MAX;
      end else if (in_valid) begin
         if (shift_dir_e'(dir) == SHIFT_RIGHT) begin
            outgoing  = window[0];
            window_nx = {in_bit, window[DEPTH-1:1]};
         end else begin
            outgoing  = window[DEPTH-1];
            window_nx = {window[DEPTH-2:0], in_bit};
         end
         bit_out_nx = outgoing;
         // An outgoing one implies window_ones >= 1, so this never wraps.
         ones_nx      = window_ones + ONES_W'(in_bit) - ONES_W'(outgoing);
         fill_nx      = full ? fill : fill + ONES_W'(1);
         out_valid_nx = full;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         window      <= '0;
         window_ones <= '0;
         fill        <= '0;
         bit_out     <= 1'b0;
         out_valid   <= 1'b0;
         match       <= 1'b0;
      end else begin
         window      <= window_nx;
         window_ones <= ones_nx;
         fill        <= fill_nx;
         bit_out     <= bit_out_nx;
         out_valid   <= out_valid_nx;
         // Built from next-state values so it lines up with the new window.
         match       <= (fill_nx == FILL_MAX) && (window_nx == PATTERN);
      end
   end

   sat_counter #(
      .W (COUNT_W)
   ) u_total (
      .clk   (clk),
      .reset (reset),
      .inc   (in_valid & in_bit & ~load),
      .clr   (clr_count),
      .count (total_count),
      .sat   (total_sat)
   );

endmodule

// File: tb/tb_shift_window_counter.sv
// Bench for shift_window_counter: two instances (32-bit and 3-bit totals)
// against an arithmetic reference model, plus directed literal expectations.
module tb_shift_window_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_bit;
   logic       dir;
   logic       load;
   logic [7:0] load_data;
   logic       clr_count;

   logic        bit_out_a, out_valid_a, total_sat_a, full_a, match_a;
   logic [7:0]  window_a;
   logic [3:0]  window_ones_a;
   logic [31:0] total_count_a;
   logic        bit_out_b, out_valid_b, total_sat_b, full_b, match_b;
   logic [7:0]  window_b;
   logic [3:0]  window_ones_b;
   logic [2:0]  total_count_b;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model state (plain integers)
   int      m_win, m_fill, m_bo, m_ov;
   longint  m_cnt_a;
   int      m_cnt_b;
   bit      m_sat_a, m_sat_b;

   always #5 clk = ~clk;

   shift_window_counter #(.DEPTH(8), .COUNT_W(32), .PATTERN(8'hA5)) dut_a (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .dir(dir),
      .load(load), .load_data(load_data), .clr_count(clr_count),
      .bit_out(bit_out_a), .out_valid(out_valid_a), .window(window_a),
      .window_ones(window_ones_a), .total_count(total_count_a),
      .total_sat(total_sat_a), .full(full_a), .match(match_a)
   );

   shift_window_counter #(.DEPTH(8), .COUNT_W(3), .PATTERN(8'hA5)) dut_b (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .dir(dir),
      .load(load), .load_data(load_data), .clr_count(clr_count),
      .bit_out(bit_out_b), .out_valid(out_valid_b), .window(window_b),
      .window_ones(window_ones_b), .total_count(total_count_b),
      .total_sat(total_sat_b), .full(full_b), .match(match_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: window as an integer 0..255, shifts as multiply/divide.
   always @(posedge clk) begin
      if (reset) begin
         m_win = 0; m_fill = 0; m_bo = 0; m_ov = 0;
         m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 0; m_sat_b = 0;
      end else begin
         bit inc;
         inc  = in_valid && in_bit && !load;
         m_ov = 0;
         if (load) begin
            m_win  = int'(load_data);
            m_fill = 8;
         end else if (in_valid) begin
            m_ov = (m_fill == 8) ? 1 : 0;
            if (dir) begin
               m_bo  = m_win % 2;
               m_win = m_win / 2 + 128 * int'(in_bit);
            end else begin
               m_bo  = m_win / 128;
               m_win = (m_win * 2 + int'(in_bit)) % 256;
            end
            m_fill = (m_fill < 8) ? m_fill + 1 : 8;
         end
         if (clr_count) begin
            m_cnt_a = inc ? 1 : 0; m_sat_a = 0;
            m_cnt_b = inc ? 1 : 0; m_sat_b = 0;
         end else begin
            if (inc && m_cnt_a < 64'hFFFF_FFFF) m_cnt_a++;
            if (inc && m_cnt_b < 7) m_cnt_b++;
            if (m_cnt_a == 64'hFFFF_FFFF) m_sat_a = 1;
            if (m_cnt_b == 7) m_sat_b = 1;
         end
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("window_a", 64'(window_a), 64'(m_win));
         check("window_b", 64'(window_b), 64'(m_win));
         check("bit_out_a", 64'(bit_out_a), 64'(m_bo));
         check("bit_out_b", 64'(bit_out_b), 64'(m_bo));
         check("out_valid_a", 64'(out_valid_a), 64'(m_ov));
         check("out_valid_b", 64'(out_valid_b), 64'(m_ov));
         check("window_ones_a", 64'(window_ones_a), 64'($countones(m_win)));
         check("window_ones_b", 64'(window_ones_b), 64'($countones(m_win)));
         check("full_a", 64'(full_a), 64'(m_fill == 8));
         check("full_b", 64'(full_b), 64'(m_fill == 8));
         check("match_a", 64'(match_a), 64'(m_fill == 8 && m_win == 'hA5));
         check("match_b", 64'(match_b), 64'(m_fill == 8 && m_win == 'hA5));
         check("total_count_a", 64'(total_count_a), 64'(m_cnt_a));
         check("total_sat_a", 64'(total_sat_a), 64'(m_sat_a));
         check("total_count_b", 64'(total_count_b), 64'(m_cnt_b));
         check("total_sat_b", 64'(total_sat_b), 64'(m_sat_b));
      end
   end

   task automatic cyc(input bit r, input bit iv, input bit ib, input bit d,
                      input bit ld, input logic [7:0] ldd, input bit clr);
      @(negedge clk);
      reset = r; in_valid = iv; in_bit = ib; dir = d;
      load = ld; load_data = ldd; clr_count = clr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] seq;
      logic [7:0]  got;
      int          k;

      reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; dir = 1'b0;
      load = 1'b0; load_data = 8'h00; clr_count = 1'b0;
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      chk_en = 1'b1;
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      check("reset_window", 64'(window_a), 64'h0);
      check("reset_count", 64'(total_count_a), 64'h0);
      check("reset_full", 64'(full_a), 64'h0);

      // 16'hF0A4 LSB-first, left shift
      seq = 16'hF0A4;
      got = 8'h00;
      k   = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, seq[i], 0, 0, 8'h00, 0);
         if (i == 6) check("full_before_8th", 64'(full_a), 64'h0);
         if (i == 7) check("full_after_8th", 64'(full_a), 64'h1);
         if (i == 7) check("no_out_valid_8th", 64'(out_valid_a), 64'h0);
         if (i == 8) check("out_valid_9th", 64'(out_valid_a), 64'h1);
         if (out_valid_a && k < 8) begin
            got[k] = bit_out_a;
            k++;
         end
      end
      check("out_pulses", 64'(k), 64'd8);
      check("bit_out_seq", 64'(got), 64'hA4);
      check("total_after_seq", 64'(total_count_a), 64'd7);
      check("window_after_seq", 64'(window_a), 64'h0F);

      // Load pattern, then one right shift of a zero
      cyc(0, 0, 0, 0, 1, 8'hA5, 0);
      check("load_full", 64'(full_a), 64'h1);
      check("load_ones", 64'(window_ones_a), 64'd4);
      check("load_match", 64'(match_a), 64'h1);
      check("load_no_ov", 64'(out_valid_a), 64'h0);
      cyc(0, 1, 0, 1, 0, 8'h00, 0);
      check("rshift_window", 64'(window_a), 64'h52);
      check("rshift_bit_out", 64'(bit_out_a), 64'h1);
      check("rshift_out_valid", 64'(out_valid_a), 64'h1);
      check("rshift_match", 64'(match_a), 64'h0);

      // Saturation on the 3-bit instance
      cyc(1, 0, 0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 9; i++) cyc(0, 1, 1, 0, 0, 8'h00, 0);
      check("sat3_count", 64'(total_count_b), 64'd7);
      check("sat3_flag", 64'(total_sat_b), 64'h1);
      check("wide_count_9", 64'(total_count_a), 64'd9);
      cyc(0, 1, 1, 0, 0, 8'h00, 1);
      check("clr_inc_count", 64'(total_count_b), 64'd1);
      check("clr_inc_sat", 64'(total_sat_b), 64'h0);
      check("clr_inc_wide", 64'(total_count_a), 64'd1);

      // in_valid toggling every other cycle, mixed directions
      for (int i = 0; i < 40; i++) begin
         cyc(0, i[0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 8'h00, 0);
      end

      // Reset together with load and in_valid mid-stream
      cyc(0, 0, 0, 0, 1, 8'hA5, 0);
      cyc(1, 1, 1, 0, 1, 8'hFF, 0);
      check("midrst_window", 64'(window_a), 64'h0);
      check("midrst_bit_out", 64'(bit_out_a), 64'h0);
      check("midrst_out_valid", 64'(out_valid_a), 64'h0);
      check("midrst_ones", 64'(window_ones_a), 64'h0);
      check("midrst_full", 64'(full_a), 64'h0);
      check("midrst_match", 64'(match_a), 64'h0);
      check("midrst_count", 64'(total_count_a), 64'h0);
      check("midrst_sat", 64'(total_sat_b), 64'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] ldd;
         ldd = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
         cyc($urandom_range(0, 63) == 0,
             $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             $urandom_range(0, 15) == 0,
             ldd,
             $urandom_range(0, 31) == 0);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
